subtractor_16bit_pipe: RTL

SUBTRACTOR_16BIT_PIPE -- requirements
Module: subtractor_16bit_pipe

---
 rtl/subtractor_16bit_pipe_pkg.sv | 15 +
 rtl/subtractor_16bit_pipe_if.sv | 20 ++
 rtl/sub_slice.sv | 10 +
 rtl/subtractor_16bit_pipe.sv | 77 +++++++
 4 files changed

// File: rtl/subtractor_16bit_pipe_pkg.sv
// subtractor_16bit_pipe_pkg: shared width constant and stage-1 payload type (SUB16_OVF_EN adds sign bits)
package sub_pkg;
    localparam int SUB_WIDTH = 16;
    localparam int SUB_HALF  = SUB_WIDTH / 2;
    typedef struct packed {
        logic [SUB_HALF-1:0] lo_y;
        logic                lo_bo;
        logic [SUB_HALF-1:0] hi_a;
        logic [SUB_HALF-1:0] hi_b;
`ifdef SUB16_OVF_EN
        logic                sa;
        logic                sb;
`endif
    } s1_t;
endpackage

// File: rtl/subtractor_16bit_pipe_if.sv
// subtractor_16bit_pipe_if: operand/result valid-ready bundle (SUB16_OVF_EN adds ovf)
interface subtractor_16bit_pipe_if import sub_pkg::*; #(parameter int WIDTH = SUB_WIDTH);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] y;
    logic             Bo;
    logic             out_valid;
    logic             out_ready;
`ifdef SUB16_OVF_EN
    logic             ovf;
    modport slave  (input a, b, b_in, in_valid, out_ready, output in_ready, y, Bo, out_valid, ovf);
    modport master (output a, b, b_in, in_valid, out_ready, input in_ready, y, Bo, out_valid, ovf);
`else
    modport slave  (input a, b, b_in, in_valid, out_ready, output in_ready, y, Bo, out_valid);
    modport master (output a, b, b_in, in_valid, out_ready, input in_ready, y, Bo, out_valid);
`endif
endinterface

// File: rtl/sub_slice.sv
// sub_slice: combinational W-bit subtractor with borrow in and borrow out
module sub_slice #(parameter int W = 8) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_bin,
    output logic [W-1:0] o_y,
    output logic         o_bo
);
    assign {o_bo, o_y} = {1'b0, i_a} - {1'b0, i_b} - {{W{1'b0}}, i_bin};
endmodule

// File: rtl/subtractor_16bit_pipe.sv
// subtractor_16bit_pipe: two-stage valid/ready a-b-b_in, split at WIDTH/2 (SUB16_OVF_EN adds signed overflow)
module subtractor_16bit_pipe import sub_pkg::*; #(parameter int WIDTH = SUB_WIDTH) (
    input logic clk,
    input logic rst,
    subtractor_16bit_pipe_if.slave bus
);
    localparam int HW = WIDTH / 2;
    s1_t              r_s1;
    s1_t              w_s1_d;
    logic             r_s1_v;
    logic             r_s2_v;
    logic [WIDTH-1:0] r_y;
    logic             r_bo;
    logic [HW-1:0]    w_lo_y;
    logic [HW-1:0]    w_hi_y;
    logic             w_lo_bo;
    logic             w_hi_bo;
    logic             w_s2_rdy;
    logic             w_s1_rdy;
`ifdef SUB16_OVF_EN
    logic             r_ovf;
    assign bus.ovf = r_ovf;
`endif
    sub_slice #(.W(HW)) u_lo (
        .i_a(bus.a[HW-1:0]), .i_b(bus.b[HW-1:0]), .i_bin(bus.b_in), .o_y(w_lo_y), .o_bo(w_lo_bo)
    );
    sub_slice #(.W(HW)) u_hi (
        .i_a(r_s1.hi_a), .i_b(r_s1.hi_b), .i_bin(r_s1.lo_bo), .o_y(w_hi_y), .o_bo(w_hi_bo)
    );
    assign w_s2_rdy      = !r_s2_v || bus.out_ready;
    assign w_s1_rdy      = !r_s1_v || w_s2_rdy;
    assign bus.in_ready  = w_s1_rdy;
    assign bus.y         = r_y;
    assign bus.Bo        = r_bo;
    assign bus.out_valid = r_s2_v;
    // stage-1 payload: low-half result/borrow plus the high-half operands
    always_comb begin
        w_s1_d.lo_y  = w_lo_y;
        w_s1_d.lo_bo = w_lo_bo;
        w_s1_d.hi_a  = bus.a[WIDTH-1:HW];
        w_s1_d.hi_b  = bus.b[WIDTH-1:HW];
`ifdef SUB16_OVF_EN
        w_s1_d.sa    = bus.a[WIDTH-1];
        w_s1_d.sb    = bus.b[WIDTH-1];
`endif
    end
    // stage 1 advances whenever it is empty or stage 2 can take its content
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v <= 1'b0;
            r_s1   <= '0;
        end else if (w_s1_rdy) begin
            r_s1_v <= bus.in_valid;
            if (bus.in_valid) r_s1 <= w_s1_d;
        end
    end
    // stage 2 holds the result until it is taken; bubbles leave the old data untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_v <= 1'b0;
            r_y    <= '0;
            r_bo   <= 1'b0;
`ifdef SUB16_OVF_EN
            r_ovf  <= 1'b0;
`endif
        end else if (w_s2_rdy) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_y   <= {w_hi_y, r_s1.lo_y};
                r_bo  <= w_hi_bo;
`ifdef SUB16_OVF_EN
                r_ovf <= (r_s1.sa != r_s1.sb) && (w_hi_y[HW-1] != r_s1.sa);
`endif
            end
        end
    end
endmodule
